// File: rtl/s_block_writer.sv
// s_block_writer: reads one 8x8 block of S values, clips each to 8 bits,
// packs two pixels per word and writes 32 words into the Y/U/V SRAM region.
// Build option: define SBW_SHIFT_EN to take raw 32-bit MAC output and
// arithmetic-shift it right by 16 before clipping. Timing is unchanged.
module s_block_writer #(
  parameter logic [17:0] Y_BASE       = 18'd0,
  parameter logic [17:0] U_BASE       = 18'd38400,
  parameter logic [17:0] V_BASE       = 18'd57600,
  parameter logic [17:0] Y_ROW_WORDS  = 18'd160,
  parameter logic [17:0] UV_ROW_WORDS = 18'd80
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        start,
  input  logic [1:0]  plane,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  output logic [6:0]  s_read_address,
  input  logic [31:0] s_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] PLANE_Y   = 2'd0;
  localparam logic [1:0] PLANE_U   = 2'd1;
  localparam logic [1:0] PLANE_BAD = 2'd3;
  localparam logic [6:0] LAST_ADDR = 7'd63;

  state_t      state_q, state_d;
  logic [6:0]  rd_addr_q, rd_addr_d;
  logic        rd_vld_q, rd_vld_d;
  logic        dat_vld_q, dat_vld_d;
  logic [5:0]  dat_idx_q, dat_idx_d;
  logic [1:0]  plane_q, plane_d;
  logic [4:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic [7:0]  px_q, px_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic signed [31:0] v_c;
  logic [7:0]         pix_c;
  logic [17:0]        base_c;
  logic [17:0]        row_words_c;
  logic [7:0]         pix_row_c;
  logic [17:0]        addr_c;

  // Scale (optional) and clip the S value currently on the RAM output
  always_comb begin
    v_c   = $signed(s_read_data);
`ifdef SBW_SHIFT_EN
    v_c   = $signed(s_read_data) >>> 16;
`else
    v_c   = $signed(s_read_data);
`endif
    pix_c = v_c[7:0];
    if (v_c < 32'sd0) begin
      pix_c = 8'd0;
    end else if (v_c > 32'sd255) begin
      pix_c = 8'd255;
    end
  end

  // SRAM word address of the word completed by the current odd pixel
  always_comb begin
    case (plane_q)
      PLANE_Y: begin
        base_c      = Y_BASE;
        row_words_c = Y_ROW_WORDS;
      end
      PLANE_U: begin
        base_c      = U_BASE;
        row_words_c = UV_ROW_WORDS;
      end
      default: begin
        base_c      = V_BASE;
        row_words_c = UV_ROW_WORDS;
      end
    endcase
    pix_row_c = {row_q, dat_idx_q[5:3]};
    addr_c    = base_c + (18'(pix_row_c) * row_words_c)
              + 18'({col_q, 2'b00}) + 18'(dat_idx_q[2:1]);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    plane_d     = plane_q;
    row_d       = row_q;
    col_d       = col_q;
    px_d        = px_q;
    sram_addr_d = sram_addr_q;
    wdata_d     = wdata_q;
    we_n_d      = 1'b1;
    dat_vld_d   = rd_vld_q;
    dat_idx_d   = rd_addr_q[5:0];

    case (state_q)
      S_IDLE: begin
        if (start && (plane != PLANE_BAD)) begin
          state_d   = S_READ;
          rd_addr_d = 7'd0;
          plane_d   = plane;
          row_d     = block_row;
          col_d     = block_col;
        end
      end
      S_READ: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 7'd1;
        end
      end
      S_DRAIN: begin
        // The last word is on the bus this cycle when the strobe is low
        if (!we_n_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Even pixels wait in px_q; odd pixels complete a word
    if (dat_vld_q) begin
      if (!dat_idx_q[0]) begin
        px_d = pix_c;
      end else begin
        we_n_d      = 1'b0;
        wdata_d     = {px_q, pix_c};
        sram_addr_d = addr_c;
      end
    end

    rd_vld_d = (state_d == S_READ);
    busy_d   = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= 7'd0;
      rd_vld_q    <= 1'b0;
      dat_vld_q   <= 1'b0;
      dat_idx_q   <= 6'd0;
      plane_q     <= 2'd0;
      row_q       <= 5'd0;
      col_q       <= 6'd0;
      px_q        <= 8'd0;
      sram_addr_q <= 18'd0;
      wdata_q     <= 16'd0;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_vld_q    <= rd_vld_d;
      dat_vld_q   <= dat_vld_d;
      dat_idx_q   <= dat_idx_d;
      plane_q     <= plane_d;
      row_q       <= row_d;
      col_q       <= col_d;
      px_q        <= px_d;
      sram_addr_q <= sram_addr_d;
      wdata_q     <= wdata_d;
      we_n_q      <= we_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign s_read_address  = rd_addr_q;
  assign SRAM_address    = sram_addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
